// File: rtl/mix_chain_sequencer.sv
// Valve sequencer for NCH-inlet mixer chains: dose ch0, dose ch1..NCH-1 each followed by a settle, then drain.
// Optional abort-to-drain is compiled in only when MIX_CHAIN_ABORT_EN is defined.
module mix_chain_sequencer #(
  parameter int NCH   = 3,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NCH*CNT_W-1:0]     dwell_cfg,
  input  logic [CNT_W-1:0]         mix_cfg,
  input  logic [CNT_W-1:0]         drain_cfg,
  output logic [NCH-1:0]           valve_open,
  output logic                     outlet_open,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [$clog2(NCH)-1:0]   cur_ch
);
  localparam int CH_W = $clog2(NCH);
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NCH - 1);
  localparam logic [CH_W-1:0]  ONE_CH  = 1;
  localparam logic [CNT_W-1:0] ONE     = 1;
  localparam logic [NCH-1:0]   VBIT    = 1;

  typedef enum logic [2:0] {S_IDLE, S_DOSE, S_MIX, S_DRAIN, S_DONE} state_t;

  state_t                 r_state, w_nstate, w_e_state;
  logic [CH_W-1:0]        r_ch, w_nch, w_e_ch;
  logic [CNT_W-1:0]       r_cnt, w_ncnt, w_dur;
  logic [NCH*CNT_W-1:0]   r_dwell, w_dwell_src;
  logic [CNT_W-1:0]       r_mix, r_drain, w_mix_src, w_drain_src;
  logic                   r_aborted, w_naborted;
  logic                   w_resolve, w_stop, w_abort_hit;
  logic [NCH-1:0]         r_valve, w_valve;
  logic                   r_outlet, r_busy, r_done, w_outlet, w_busy, w_done;

`ifdef MIX_CHAIN_ABORT_EN
  assign w_abort_hit = abort;
`else
  logic w_unused_abort;
  assign w_unused_abort = abort;
  assign w_abort_hit    = 1'b0;
`endif

  // The run's first state is resolved in the start cycle, before the latch holds the config.
  assign w_dwell_src = (r_state == S_IDLE) ? dwell_cfg : r_dwell;
  assign w_mix_src   = (r_state == S_IDLE) ? mix_cfg   : r_mix;
  assign w_drain_src = (r_state == S_IDLE) ? drain_cfg : r_drain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ch      <= '0;
      r_cnt     <= '0;
      r_dwell   <= '0;
      r_mix     <= '0;
      r_drain   <= '0;
      r_aborted <= 1'b0;
      r_valve   <= '0;
      r_outlet  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_ch      <= w_nch;
      r_cnt     <= w_ncnt;
      r_aborted <= w_naborted;
      r_valve   <= w_valve;
      r_outlet  <= w_outlet;
      r_busy    <= w_busy;
      r_done    <= w_done;
      if (r_state == S_IDLE && start) begin
        r_dwell <= dwell_cfg;
        r_mix   <= mix_cfg;
        r_drain <= drain_cfg;
      end
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_nch      = r_ch;
    w_ncnt     = r_cnt - ONE;
    w_naborted = r_aborted;
    w_e_state  = S_DONE;
    w_e_ch     = r_ch;
    w_resolve  = 1'b0;
    w_stop     = 1'b0;
    w_dur      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_e_state  = S_DOSE;
          w_e_ch     = '0;
          w_resolve  = 1'b1;
          w_naborted = 1'b0;
        end
      end
      S_DOSE, S_MIX: begin
        if (w_abort_hit) begin
          w_e_state  = S_DRAIN;
          w_resolve  = 1'b1;
          w_naborted = 1'b1;
        end else if (r_cnt == ONE) begin
          w_resolve = 1'b1;
          if (r_state == S_DOSE) begin
            if (r_ch == '0) begin
              w_e_state = S_DOSE;
              w_e_ch    = ONE_CH;
            end else begin
              w_e_state = S_MIX;
            end
          end else if (r_ch == LAST_CH) begin
            w_e_state = S_DRAIN;
          end else begin
            w_e_state = S_DOSE;
            w_e_ch    = r_ch + ONE_CH;
          end
        end
      end
      S_DRAIN: begin
        if (r_cnt == ONE) begin
          w_e_state = S_DONE;
          w_resolve = 1'b1;
        end
      end
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
    // Walk forward past zero-length states so the whole chain collapses into this edge.
    if (w_resolve) begin
      for (int i = 0; i < 2*NCH + 2; i++) begin
        if (!w_stop) begin
          case (w_e_state)
            S_DOSE:  w_dur = w_dwell_src[w_e_ch*CNT_W +: CNT_W];
            S_MIX:   w_dur = w_mix_src;
            S_DRAIN: w_dur = w_drain_src;
            default: w_dur = '0;
          endcase
          if (w_e_state == S_DONE || w_dur != '0) begin
            w_stop   = 1'b1;
            w_nstate = w_e_state;
            w_nch    = w_e_ch;
            w_ncnt   = w_dur;
          end else begin
            case (w_e_state)
              S_DOSE: begin
                if (w_e_ch == '0) w_e_ch = ONE_CH;
                else              w_e_state = S_MIX;
              end
              S_MIX: begin
                if (w_e_ch == LAST_CH) begin
                  w_e_state = S_DRAIN;
                end else begin
                  w_e_state = S_DOSE;
                  w_e_ch    = w_e_ch + ONE_CH;
                end
              end
              default: w_e_state = S_DONE;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    w_valve  = (w_nstate == S_DOSE) ? (VBIT << w_nch) : '0;
    w_outlet = (w_nstate == S_DRAIN);
    w_busy   = (w_nstate == S_DOSE) || (w_nstate == S_MIX) || (w_nstate == S_DRAIN);
    w_done   = (w_nstate == S_DONE);
  end

  assign valve_open  = r_valve;
  assign outlet_open = r_outlet;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign cur_ch      = r_ch;
endmodule

// File: tb/tb_mix_chain_sequencer.sv
// Directed bench for mix_chain_sequencer: nominal, zero fields, abort, busy/config stability, reset, 16-channel limit.
module tb_mix_chain_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [47:0] dwell_cfg;
  logic [15:0] mix_cfg, drain_cfg;
  logic [2:0]  valve_open;
  logic        outlet_open, busy, done, aborted;
  logic [1:0]  cur_ch;

  logic        start2, abort2;
  logic [63:0] dwell2;
  logic [3:0]  mix2, drain2;
  logic [15:0] valve2;
  logic        outlet2, busy2, done2, aborted2;
  logic [3:0]  cur_ch2;

  int checks = 0;
  int errors = 0;

  logic [2:0] cv [0:40];
  logic       co [0:40];
  logic       cb [0:40];
  logic       cd [0:40];
  logic       ca [0:40];
  logic [1:0] cc [0:40];

  mix_chain_sequencer #(.NCH(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dwell_cfg(dwell_cfg), .mix_cfg(mix_cfg), .drain_cfg(drain_cfg),
    .valve_open(valve_open), .outlet_open(outlet_open), .busy(busy),
    .done(done), .aborted(aborted), .cur_ch(cur_ch)
  );

  mix_chain_sequencer #(.NCH(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
    .dwell_cfg(dwell2), .mix_cfg(mix2), .drain_cfg(drain2),
    .valve_open(valve2), .outlet_open(outlet2), .busy(busy2),
    .done(done2), .aborted(aborted2), .cur_ch(cur_ch2)
  );

  always #5 clk = ~clk;

  // Expected {valve[2:0], outlet, busy, done} for the nominal run {4,5,6}/3/2.
  function automatic logic [5:0] nom_exp(input int k);
    logic [2:0] v;
    v = (k >= 1 && k <= 4) ? 3'b001 : (k >= 5 && k <= 9) ? 3'b010 :
        (k >= 13 && k <= 18) ? 3'b100 : 3'b000;
    return {v, (k == 22 || k == 23), (k >= 1 && k <= 23), (k == 24)};
  endfunction

  // Abort sampled at the end of cycle 6 of the nominal run.
  function automatic logic [5:0] abort_exp(input int k);
    logic [2:0] v;
    v = (k >= 1 && k <= 4) ? 3'b001 : (k >= 5 && k <= 6) ? 3'b010 : 3'b000;
    return {v, (k == 7 || k == 8), (k >= 1 && k <= 8), (k == 9)};
  endfunction

  task automatic set_nominal();
    dwell_cfg = {16'd6, 16'd5, 16'd4};
    mix_cfg   = 16'd3;
    drain_cfg = 16'd2;
  endtask

  task automatic capture(input int ncyc, input int abort_cyc, input int s1, input int s2, input int chg_cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      cv[k] = valve_open; co[k] = outlet_open; cb[k] = busy;
      cd[k] = done;       ca[k] = aborted;     cc[k] = cur_ch;
      abort = (k == abort_cyc);
      start = (k == s1) || (k == s2);
      if (k == chg_cyc) dwell_cfg = {16'd9, 16'd9, 16'd9};
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({valve_open, outlet_open, busy, done, aborted, cur_ch} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0", {valve_open, outlet_open, busy, done, aborted, cur_ch});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [1:0] exp_ch [0:3];
    int         cyc_ch [0:3];
    set_nominal();
    capture(26, 0, 0, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      checks++;
      if ({cv[k], co[k], cb[k], cd[k]} !== nom_exp(k)) begin
        errors++;
        $display("FAIL nominal cyc %0d got %b exp %b", k, {cv[k], co[k], cb[k], cd[k]}, nom_exp(k));
      end
    end
    cyc_ch = '{1, 6, 20, 24};
    exp_ch = '{2'd0, 2'd1, 2'd2, 2'd2};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cc[cyc_ch[i]] !== exp_ch[i]) begin
        errors++;
        $display("FAIL nominal_cur_ch cyc %0d got %0d exp %0d", cyc_ch[i], cc[cyc_ch[i]], exp_ch[i]);
      end
    end
    checks++;
    if (ca[12] !== 1'b0) begin
      errors++;
      $display("FAIL nominal_aborted got %b exp 0", ca[12]);
    end
  endtask

  task automatic test_zero_fields();
    logic [5:0] e;
    dwell_cfg = {16'd0, 16'd3, 16'd0};
    mix_cfg   = 16'd0;
    drain_cfg = 16'd0;
    capture(6, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      e = {(k <= 3) ? 3'b010 : 3'b000, 1'b0, (k <= 3), (k == 4)};
      checks++;
      if ({cv[k], co[k], cb[k], cd[k]} !== e) begin
        errors++;
        $display("FAIL zero_fields cyc %0d got %b exp %b", k, {cv[k], co[k], cb[k], cd[k]}, e);
      end
    end
    dwell_cfg = '0;
    capture(3, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      e = {5'b00000, (k == 1)};
      checks++;
      if ({cv[k], co[k], cb[k], cd[k]} !== e) begin
        errors++;
        $display("FAIL all_zero cyc %0d got %b exp %b", k, {cv[k], co[k], cb[k], cd[k]}, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [5:0] e;
    logic       ea;
    set_nominal();
    capture(26, 6, 0, 0, 0);
    for (int k = 1; k <= 26; k++) begin
`ifdef MIX_CHAIN_ABORT_EN
      e  = abort_exp(k);
      ea = (k >= 7);
`else
      e  = nom_exp(k);
      ea = 1'b0;
`endif
      checks++;
      if ({cv[k], co[k], cb[k], cd[k]} !== e) begin
        errors++;
        $display("FAIL abort cyc %0d got %b exp %b", k, {cv[k], co[k], cb[k], cd[k]}, e);
      end
      checks++;
      if (ca[k] !== ea) begin
        errors++;
        $display("FAIL abort_flag cyc %0d got %b exp %b", k, ca[k], ea);
      end
    end
  endtask

  task automatic test_busy_config();
    set_nominal();
    capture(26, 0, 3, 10, 2);
    for (int k = 1; k <= 26; k++) begin
      checks++;
      if ({cv[k], co[k], cb[k], cd[k]} !== nom_exp(k)) begin
        errors++;
        $display("FAIL busy_config cyc %0d got %b exp %b", k, {cv[k], co[k], cb[k], cd[k]}, nom_exp(k));
      end
    end
    checks++;
    if (ca[1] !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_aborted got %b exp 0", ca[1]);
    end
    set_nominal();
  endtask

  task automatic test_reset_midrun();
    set_nominal();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (valve_open !== 3'b010) begin
      errors++;
      $display("FAIL pre_reset_valve got %b exp 010", valve_open);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valve_open, outlet_open, busy, done, aborted, cur_ch} !== 9'd0) begin
      errors++;
      $display("FAIL async_reset got %b exp 0", {valve_open, outlet_open, busy, done, aborted, cur_ch});
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(26, 0, 0, 0, 0);
    for (int k = 1; k <= 26; k++) begin
      checks++;
      if ({cv[k], co[k], cb[k], cd[k]} !== nom_exp(k)) begin
        errors++;
        $display("FAIL after_reset cyc %0d got %b exp %b", k, {cv[k], co[k], cb[k], cd[k]}, nom_exp(k));
      end
    end
  endtask

  task automatic test_limit();
    int done_cyc = 0;
    int multi = 0;
    int vcnt = 0;
    int ocnt = 0;
    int bcnt = 0;
    dwell2 = {64{1'b1}};
    mix2   = 4'd15;
    drain2 = 4'd15;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      if ($countones(valve2) > 1) multi++;
      if (valve2 != '0) vcnt++;
      if (outlet2) ocnt++;
      if (busy2) bcnt++;
      if (done2) begin
        done_cyc = k;
        break;
      end
    end
    checks++;
    if (done_cyc != 481) begin
      errors++;
      $display("FAIL limit_done_cycle got %0d exp 481", done_cyc);
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL limit_onehot got %0d multi-valve cycles exp 0", multi);
    end
    checks++;
    if (vcnt != 240 || ocnt != 15 || bcnt != 480) begin
      errors++;
      $display("FAIL limit_counts got valve %0d outlet %0d busy %0d exp 240 15 480", vcnt, ocnt, bcnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    dwell2 = '0; mix2 = '0; drain2 = '0;
    set_nominal();
    test_reset();
    test_nominal();
    test_zero_fields();
    test_abort();
    test_busy_config();
    test_reset_midrun();
    test_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
